// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, write enables and ALU op code each cycle.
module mc_ctrl_fsm #(
    parameter logic [2:0] ALU_ADD = 3'b010,
    parameter logic [2:0] ALU_SUB = 3'b110,
    parameter logic [2:0] ALU_AND = 3'b000,
    parameter logic [2:0] ALU_OR  = 3'b001,
    parameter logic [2:0] ALU_SLT = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memwrite,
    output logic       memread,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] pcsrc;
        logic       iord;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
    } moore_t;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // State-decoded outputs, evaluated for the state about to be entered so they
    // can be registered alongside it.
    function automatic moore_t moore_for(input state_t s, input logic [5:0] f);
        moore_t m;
        m = '0;
        m.alucontrol = ALU_ADD;
        case (s)
            S_FETCH: begin
                m.memread = 1'b1;
                m.alusrcb = 2'b01;
            end
            S_DECODE: m.alusrcb = 2'b11;
            S_MEMADR: begin
                m.alusrca = 1'b1;
                m.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                m.iord    = 1'b1;
                m.memread = 1'b1;
            end
            S_MEMWB: begin
                m.regwrite = 1'b1;
                m.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                m.iord     = 1'b1;
                m.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                m.alusrca    = 1'b1;
                m.alucontrol = funct_alu(f);
            end
            S_ALUWB: begin
                m.regwrite = 1'b1;
                m.regdst   = 1'b1;
            end
            S_BRANCH: begin
                m.alusrca    = 1'b1;
                m.alucontrol = ALU_SUB;
                m.pcsrc      = 2'b01;
            end
            S_ADDIEXEC: begin
                m.alusrca = 1'b1;
                m.alusrcb = 2'b10;
            end
            S_ADDIWB: m.regwrite = 1'b1;
            S_JUMP:   m.pcsrc    = 2'b10;
            default: ;
        endcase
        return m;
    endfunction

    state_t cur;
    state_t nxt;
    moore_t mo;
    logic   decode_legal;

    always_comb begin
        decode_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_legal = 1'b1;
            OP_RTYPE: decode_legal = funct_legal(funct);
            default:  decode_legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!decode_legal)       nxt = S_FETCH;
                else if (opcode == OP_LW || opcode == OP_SW) nxt = S_MEMADR;
                else if (opcode == OP_RTYPE) nxt = S_EXECUTE;
                else if (opcode == OP_BEQ)   nxt = S_BRANCH;
                else if (opcode == OP_ADDI)  nxt = S_ADDIEXEC;
                else                         nxt = S_JUMP;
            end
            S_MEMADR:   nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  nxt = S_ALUWB;
            S_ADDIEXEC: nxt = S_ADDIWB;
            default:    nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur <= S_FETCH;
            mo  <= moore_for(S_FETCH, '0);
        end else begin
            cur <= nxt;
            mo  <= moore_for(nxt, funct);
        end
    end

    logic in_fetch;
    logic in_decode;
    logic in_branch;
    logic in_jump;

    assign in_fetch  = (cur == S_FETCH);
    assign in_decode = (cur == S_DECODE);
    assign in_branch = (cur == S_BRANCH);
    assign in_jump   = (cur == S_JUMP);

    // Enables are masked by resetn so nothing is written while reset is held,
    // even though the registered FETCH decode is already loaded.
    assign irwrite  = resetn & in_fetch & mem_ready;
    assign pcen     = resetn & ((in_fetch & mem_ready) | (in_branch & zero) | in_jump);
    assign illegal  = resetn & in_decode & ~decode_legal;
    assign memread  = resetn & mo.memread;
    assign memwrite = resetn & mo.memwrite;
    assign regwrite = resetn & mo.regwrite;

    assign pcsrc      = mo.pcsrc;
    assign iord       = mo.iord;
    assign regdst     = mo.regdst;
    assign memtoreg   = mo.memtoreg;
    assign alusrca    = mo.alusrca;
    assign alusrcb    = mo.alusrcb;
    assign alucontrol = mo.alucontrol;
    assign state      = cur;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction expected traces are queued by
// the stimulus and compared cycle by cycle by an independent monitor.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       irwrite, pcen, iord, memwrite, memread, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
        .iord(iord), .memwrite(memwrite), .memread(memread), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluc;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } item_t;

    item_t      sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;

    function automatic obs_t observed();
        obs_t o;
        o.st = state;        o.irwrite = irwrite;   o.pcen = pcen;
        o.pcsrc = pcsrc;     o.iord = iord;         o.memwrite = memwrite;
        o.memread = memread; o.regwrite = regwrite; o.regdst = regdst;
        o.memtoreg = memtoreg; o.alusrca = alusrca; o.alusrcb = alusrcb;
        o.aluc = alucontrol; o.illegal = illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: one queued expectation per clock, sampled mid-low-phase.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk(it.tag, 32'(observed()), 32'(it.v));
            end
        end
    end

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        o.aluc = 3'b010;
        return o;
    endfunction

    task automatic cyc(input string tag, input obs_t e, input logic mr, input logic z);
        @(negedge clk);
        opcode    = cur_op;
        funct     = cur_fn;
        mem_ready = mr;
        zero      = z;
        sb.push_back('{e, tag});
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Instruction kind from the decode table: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b100011) return 0;
        if (op == 6'b101011) return 1;
        if (op == 6'b000100) return 3;
        if (op == 6'b001000) return 4;
        if (op == 6'b000010) return 5;
        if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                fn == 6'b100101 || fn == 6'b101010)) return 2;
        return 6;
    endfunction

    task automatic fetch(input int fw);
        obs_t e;
        logic mr;
        for (int w = 0; w <= fw; w++) begin
            mr = (w == fw);
            e = blank(4'd0);
            e.memread = 1'b1; e.alusrcb = 2'b01;
            e.irwrite = mr;   e.pcen = mr;
            cyc("fetch", e, mr, rnd());
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        obs_t e;
        int   k;
        cur_op = op;
        cur_fn = fn;
        k = kind_of(op, fn);
        fetch(fw);
        e = blank(4'd1); e.alusrcb = 2'b11; e.illegal = (k == 6);
        cyc("decode", e, rnd(), rnd());
        case (k)
            0, 1: begin
                e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cyc("memadr", e, rnd(), rnd());
                for (int w = 0; w <= mw; w++) begin
                    e = blank((k == 0) ? 4'd3 : 4'd5); e.iord = 1'b1;
                    if (k == 0) e.memread = 1'b1; else e.memwrite = 1'b1;
                    cyc((k == 0) ? "memrd" : "memwr", e, w == mw, rnd());
                end
                if (k == 0) begin
                    e = blank(4'd4); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    cyc("memwb", e, rnd(), rnd());
                end
            end
            2: begin
                e = blank(4'd6); e.alusrca = 1'b1; e.aluc = alu_of(fn);
                cyc("execute", e, rnd(), rnd());
                e = blank(4'd7); e.regwrite = 1'b1; e.regdst = 1'b1;
                cyc("aluwb", e, rnd(), rnd());
            end
            3: begin
                e = blank(4'd8); e.alusrca = 1'b1; e.aluc = 3'b110;
                e.pcsrc = 2'b01; e.pcen = z;
                cyc("branch", e, rnd(), z);
            end
            4: begin
                e = blank(4'd9); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cyc("addiexec", e, rnd(), rnd());
                e = blank(4'd10); e.regwrite = 1'b1;
                cyc("addiwb", e, rnd(), rnd());
            end
            5: begin
                e = blank(4'd11); e.pcsrc = 2'b10; e.pcen = 1'b1;
                cyc("jump", e, rnd(), rnd());
            end
            default: ;
        endcase
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_en"}, 32'({irwrite, pcen, regwrite, memwrite, memread, illegal}), 32'd0);
    endtask

    // Release on a falling edge with memory not ready: FETCH must hold and not load IR.
    task automatic release_reset();
        obs_t e;
        @(negedge clk);
        resetn    = 1'b1;
        mem_ready = 1'b0;
        e = blank(4'd0); e.memread = 1'b1; e.alusrcb = 2'b01;
        sb.push_back('{e, "post_rst_fetch"});
    endtask

    task automatic reset_in_memrd();
        obs_t e;
        cur_op = 6'b100011;
        cur_fn = '0;
        fetch(0);
        e = blank(4'd1); e.alusrcb = 2'b11;
        cyc("decode", e, 1'b1, 1'b0);
        e = blank(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        cyc("memadr", e, 1'b1, 1'b0);
        e = blank(4'd3); e.iord = 1'b1; e.memread = 1'b1;
        cyc("memrd", e, 1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1 resetn = 1'b0;
        #1 check_in_reset("rst_async");
        @(posedge clk);
        #1 check_in_reset("rst_hold");
        release_reset();
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        int         qwait;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        resetn = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        opcode = 6'b100011; funct = '0;
        #3 check_in_reset("init_rst");
        @(posedge clk);
        #1 check_in_reset("init_rst_edge");
        release_reset();

        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);   // lw, no stalls
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);   // sw, 3 stall cycles
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);   // slt
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);   // sub
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);   // illegal funct
        run_instr(6'b001000, 6'b000000, 1'b0, 2, 0);   // addi, fetch stalls
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);   // j
        run_instr(6'b100011, 6'b000000, 1'b0, 1, 2);   // lw, both stalls
        reset_in_memrd();

        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 6)];
            fn = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            run_instr(op, fn, rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
            if (n == 150) reset_in_memrd();
        end

        qwait = 0;
        while (sb.size() != 0 && qwait < 10) begin
            @(negedge clk);
            qwait++;
        end
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS main controller; the initiator that drives the datapath ALU's 3-bit op code and operand selects each cycle.
- Sequences fetch/decode/execute/memory/writeback for lw, sw, beq, addi, j and R-type add/sub/and/or/slt.
- Sits between the instruction register (opcode/funct) and the datapath muxes, register file and memory port.
- Waits on a memory-ready handshake for instruction fetch, data load and data store.

Parameters:
- ALU_ADD, 3'b010, ALU op code for add
- ALU_SUB, 3'b110, ALU op code for subtract
- ALU_AND, 3'b000, ALU op code for AND
- ALU_OR, 3'b001, ALU op code for OR
- ALU_SLT, 3'b111, ALU op code for set-less-than

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26], stable from the cycle after FETCH completes
- funct  in  6  instr[5:0]
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current access this cycle
- irwrite  out  1  load instruction register
- pcen  out  1  PC write enable
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  0 = PC address, 1 = ALUOut address
- memwrite  out  1  store strobe
- memread  out  1  read request (fetch or load)
- regwrite  out  1  register file write enable
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = memory data, 0 = ALUOut
- alusrca  out  1  0 = PC, 1 = rs
- alusrcb  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
- alucontrol  out  3  ALU op code
- illegal  out  1  one-cycle pulse on unsupported opcode or funct
- state  out  4  current state, for debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Codes 12-15 go to FETCH on the next edge.
- Outputs are Moore, decoded from state. Exceptions:
  - mem_ready gating in FETCH.
  - zero gating in BRANCH.
  - DECODE illegal pulse.
- Default for every output is 0; default alucontrol is ALU_ADD.
- Reset: resetn low forces state=FETCH immediately.
  - While low, irwrite, pcen, regwrite, memwrite, memread and illegal are all 0.
  - Reset mid-instruction abandons it with no write.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, ALU_ADD, pcsrc=00.
  - If mem_ready: irwrite=1, pcen=1, go to DECODE. Else hold with irwrite=pcen=0.
- DECODE: alusrca=0, alusrcb=11, ALU_ADD. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 with funct in {100000, 100010, 100100, 100101, 101010} -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - Anything else (including R-type with another funct) -> illegal=1 for this cycle, go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, ALU_ADD. Next is MEMRD if opcode=100011, else MEMWR.
- MEMRD: iord=1, memread=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, go to FETCH.
- MEMWR: iord=1, memwrite=1, held asserted until mem_ready. Then go to FETCH. Exactly one write completes per sw.
- EXECUTE: alusrca=1, alusrcb=00. alucontrol by funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - Go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, ALU_SUB, pcsrc=01, pcen=zero, go to FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, ALU_ADD, go to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, go to FETCH.
- JUMP: pcsrc=10, pcen=1, go to FETCH.
- Cycle counts with mem_ready always 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- At most one of regwrite, memwrite, irwrite is high in any cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Reset, mem_ready=1, opcode=100011 -> state sequence 0,1,2,3,4,0.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0.
  - FETCH: irwrite=1 and pcen=1.
- sw (101011) with mem_ready low for 3 cycles in MEMWR -> memwrite high 4 consecutive cycles, then state 0. regwrite never 1.
- R-type funct=101010 -> EXECUTE alucontrol=111, ALUWB regwrite=1, regdst=1. Repeat for funct 100010 -> alucontrol 110.
- beq, zero=1 -> BRANCH pcen=1, pcsrc=01, alucontrol=110. With zero=0 -> pcen=0.
- opcode=111111, then R-type funct=000000 -> illegal pulses exactly 1 cycle in DECODE, next state FETCH, no regwrite or memwrite.
- resetn low for 1 cycle while in MEMRD -> state=0 asynchronously and enables 0 during reset. After release, FETCH waits on mem_ready=0 with irwrite=0.
